arb_top: RTL and testbench
==========================

Name: arb_top

Overview:
- Three-source to one-sink arbiter with registered output.
- Sources A and B are buffered, each in its own FIFO; source C is an unbuffered, highest-priority pass-through.
- One word per cycle is forwarded to sink D while D grants.
- Used where two bulk streams and one latency-critical stream share a single downstream port.

Parameters:
- WIDTH, 8, data width of all data ports.
- FIFO_DEPTH, 8, entries in each of FIFO_A and FIFO_B; power of two, >=2.

Ports:
- CLK  in  1  clock, all state on rising edge.
- ASynReset_N  in  1  asynchronous active-low reset.
- i_DataValid_A / i_DataValid_B / i_DataValid_C  in  1 each  source word present this cycle.
- i_DataIn_A / i_DataIn_B / i_DataIn_C  in  WIDTH each  source data.
- i_DataGrant_D  in  1  sink ready; one word may be transferred this cycle.
- o_DataValid_D  out  1  registered; o_DataOut_D is valid.
- o_DataOut_D  out  WIDTH  registered output word.
- o_DataGrant_A / o_DataGrant_B  out  1 each  source may write; equals !full of FIFO_A / FIFO_B.
- o_DataGrant_C  out  1  C word is accepted this cycle; equals i_DataGrant_D, combinational.

Behaviour:
- Reset (async assert, sync-safe release):
  - FIFOs empty, pointers 0, round-robin pointer = A.
  - o_DataValid_D=0, o_DataOut_D=0.
  - o_DataGrant_A=o_DataGrant_B=1; o_DataGrant_C follows i_DataGrant_D.
- FIFO write (A and B independently):
  - On edge with i_DataValid_X=1 and FIFO not full: push i_DataIn_X.
  - If full, the word is silently dropped.
  - Full is evaluated pre-edge, so a push while full is dropped even if a pop happens on the same edge.
  - No bypass: a pushed word is eligible for arbitration from the next cycle.
- Channel C:
  - No storage.
  - If i_DataValid_C=1 and i_DataGrant_D=0, the C word is lost.
- Arbitration (evaluated when i_DataGrant_D=1, decided combinationally, applied at the edge):
  1. If i_DataValid_C=1: select C. The RR pointer is unchanged.
  2. Else if exactly one of FIFO_A/FIFO_B is non-empty: select it, and set the RR pointer to the other FIFO.
  3. Else if both are non-empty: select the FIFO named by the RR pointer, and toggle the pointer.
  4. Else: no selection.
- Output register:
  - On an edge with a selection: o_DataValid_D<=1, o_DataOut_D<=selected word (FIFO head or i_DataIn_C), and the selected FIFO pops.
  - Otherwise o_DataValid_D<=0.
- Latency: C input to D output 1 cycle. A/B input to D output ≥2 cycles.
- Throughput: one word/cycle while i_DataGrant_D=1.
- A FIFO is never popped while i_DataGrant_D=0.
- Pointers wrap modulo FIFO_DEPTH; an extra wrap bit distinguishes full from empty.
- Reset mid-operation: all buffered words are discarded and the reset values are restored immediately.

Optional Feature:
- Macro ARB_OUT_HOLD_EN.
- Defined: o_DataOut_D holds its last transferred value on cycles where o_DataValid_D<=0.
- Undefined: o_DataOut_D<=0 whenever o_DataValid_D<=0.
- Valid timing and everything else are identical in both builds.

Test Plan:
- Buffer without grant:
  - Stimulus: i_DataGrant_D=0; all valid 4 cycles with A=0,3,6,9, B=1,4,7,10, C=2,5,8,11; then grant 10 cycles.
  - Response: C words lost, no D output before grant. After grant, D emits 0,1,3,4,6,7,9,10 on 8 consecutive cycles, then o_DataValid_D=0.
- C priority with grant:
  - Stimulus: i_DataGrant_D=1; all valid 4 cycles, A=12,15,18,21, B=13,16,19,22, C=14,17,20,23.
  - Response: D emits 14,17,20,23 then 12,13,15,16,18,19,21,22; 12 valid cycles total.
- Overflow:
  - Stimulus: grant=0; all valid 12 cycles with A=i*3, B=i*3+1, i=8..19.
  - Response: o_DataGrant_A/B drop to 0 after the 8th push; A=48..57 and B=49..58 dropped.
  - Then grant=1: D emits 24,25,27,28,…,45,46 (16 words), and o_DataGrant_A/B return to 1.
- Single FIFO only:
  - Stimulus: A valid 3 cycles with 5,6,7; B idle; grant=1.
  - Response: D emits 5,6,7, each 2 cycles after its input; no bubbles from B.
- Reset mid-operation:
  - Stimulus: FIFO_A holds 4 words; assert ASynReset_N low mid-cycle.
  - Response: o_DataValid_D=0 immediately; after release with grant=1, no D output.
- Optional build:
  - Stimulus: run the grant-with-gaps case.
  - Response: with ARB_OUT_HOLD_EN, o_DataOut_D keeps the last word while valid=0; without it, o_DataOut_D reads 0.

Source files
------------

// File: rtl/arb_top.sv
// Three-source arbiter: buffered A/B streams plus an unbuffered priority C stream into one registered sink port.
// Build option ARB_OUT_HOLD_EN: output word holds its last transferred value while valid is low (otherwise it reads 0).

module arb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra MSB on each pointer tells a full FIFO apart from an empty one.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Full is the pre-edge value, so a push into a full FIFO is dropped even when it pops this edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

module arb_top #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             CLK,
  input  logic             ASynReset_N,
  input  logic             i_DataValid_A,
  input  logic [WIDTH-1:0] i_DataIn_A,
  input  logic             i_DataValid_B,
  input  logic [WIDTH-1:0] i_DataIn_B,
  input  logic             i_DataValid_C,
  input  logic [WIDTH-1:0] i_DataIn_C,
  input  logic             i_DataGrant_D,
  output logic             o_DataValid_D,
  output logic [WIDTH-1:0] o_DataOut_D,
  output logic             o_DataGrant_A,
  output logic             o_DataGrant_B,
  output logic             o_DataGrant_C
);

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_e;

  rr_e              rr_q, rr_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             full_a, empty_a, full_b, empty_b;
  logic [WIDTH-1:0] head_a, head_b;
  logic             sel_a, sel_b, sel_c;

  arb_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_a (
    .clk     (CLK),
    .rst_n   (ASynReset_N),
    .push_i  (i_DataValid_A),
    .data_i  (i_DataIn_A),
    .pop_i   (sel_a),
    .full_o  (full_a),
    .empty_o (empty_a),
    .head_o  (head_a)
  );

  arb_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo_b (
    .clk     (CLK),
    .rst_n   (ASynReset_N),
    .push_i  (i_DataValid_B),
    .data_i  (i_DataIn_B),
    .pop_i   (sel_b),
    .full_o  (full_b),
    .empty_o (empty_b),
    .head_o  (head_b)
  );

  assign o_DataGrant_A = !full_a;
  assign o_DataGrant_B = !full_b;
  assign o_DataGrant_C = i_DataGrant_D;

  // C always wins and leaves the pointer alone; a lone non-empty FIFO hands the turn to the other one.
  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    sel_c = 1'b0;
    rr_d  = rr_q;
    if (i_DataGrant_D) begin
      if (i_DataValid_C) begin
        sel_c = 1'b1;
      end else if (!empty_a && empty_b) begin
        sel_a = 1'b1;
        rr_d  = RR_B;
      end else if (empty_a && !empty_b) begin
        sel_b = 1'b1;
        rr_d  = RR_A;
      end else if (!empty_a && !empty_b) begin
        if (rr_q == RR_A) begin
          sel_a = 1'b1;
          rr_d  = RR_B;
        end else begin
          sel_b = 1'b1;
          rr_d  = RR_A;
        end
      end
    end
  end

  always_comb begin
    valid_d = sel_a || sel_b || sel_c;
`ifdef ARB_OUT_HOLD_EN
    data_d  = data_q;
`else
    data_d  = '0;
`endif
    if (sel_c) begin
      data_d = i_DataIn_C;
    end else if (sel_a) begin
      data_d = head_a;
    end else if (sel_b) begin
      data_d = head_b;
    end
  end

  always_ff @(posedge CLK or negedge ASynReset_N) begin
    if (!ASynReset_N) begin
      rr_q    <= RR_A;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_DataValid_D = valid_q;
  assign o_DataOut_D   = data_q;

endmodule

// File: tb/tb_arb_top.sv
// Directed bench for arb_top: expected sink words are queued as stimulus is driven and popped as D emits.
// Idle-cycle output expectation follows ARB_OUT_HOLD_EN.

module tb_arb_top;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             ASynReset_N = 1'b0;
  logic             i_DataValid_A = 1'b0, i_DataValid_B = 1'b0, i_DataValid_C = 1'b0;
  logic [WIDTH-1:0] i_DataIn_A = '0, i_DataIn_B = '0, i_DataIn_C = '0;
  logic             i_DataGrant_D = 1'b0;
  logic             o_DataValid_D;
  logic [WIDTH-1:0] o_DataOut_D;
  logic             o_DataGrant_A, o_DataGrant_B, o_DataGrant_C;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb [$];
  logic [31:0] last_word = '0;

  always #5 CLK = ~CLK;

  arb_top #(.WIDTH(WIDTH), .FIFO_DEPTH(8)) dut (
    .CLK           (CLK),
    .ASynReset_N   (ASynReset_N),
    .i_DataValid_A (i_DataValid_A),
    .i_DataIn_A    (i_DataIn_A),
    .i_DataValid_B (i_DataValid_B),
    .i_DataIn_B    (i_DataIn_B),
    .i_DataValid_C (i_DataValid_C),
    .i_DataIn_C    (i_DataIn_C),
    .i_DataGrant_D (i_DataGrant_D),
    .o_DataValid_D (o_DataValid_D),
    .o_DataOut_D   (o_DataOut_D),
    .o_DataGrant_A (o_DataGrant_A),
    .o_DataGrant_B (o_DataGrant_B),
    .o_DataGrant_C (o_DataGrant_C)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic va, input int a, input logic vb, input int b,
                       input logic vc, input int c, input logic g);
    i_DataValid_A = va; i_DataIn_A = WIDTH'(a);
    i_DataValid_B = vb; i_DataIn_B = WIDTH'(b);
    i_DataValid_C = vc; i_DataIn_C = WIDTH'(c);
    i_DataGrant_D = g;
  endtask

  // One clock; outputs are sampled on the falling edge, then the caller drives the next inputs.
  task automatic tick();
    logic [31:0] exp;
    logic [31:0] idle_exp;
    @(posedge CLK);
    @(negedge CLK);
`ifdef ARB_OUT_HOLD_EN
    idle_exp = last_word;
`else
    idle_exp = '0;
`endif
    if (o_DataValid_D === 1'b1) begin
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        chk("dout", {24'd0, o_DataOut_D}, exp);
        last_word = exp;
      end else begin
        chk("unexpected_valid", {31'd0, o_DataValid_D}, 32'd0);
      end
    end else begin
      chk("idle_dout", {24'd0, o_DataOut_D}, idle_exp);
    end
    chk("grant_c", {31'd0, o_DataGrant_C}, {31'd0, i_DataGrant_D});
  endtask

  initial begin
    // Reset
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_valid_low", {31'd0, o_DataValid_D}, 32'd0);
    ASynReset_N = 1'b1;
    #1;
    chk("rst_valid", {31'd0, o_DataValid_D}, 32'd0);
    chk("rst_dout", {24'd0, o_DataOut_D}, 32'd0);
    chk("rst_grant_a", {31'd0, o_DataGrant_A}, 32'd1);
    chk("rst_grant_b", {31'd0, o_DataGrant_B}, 32'd1);
    chk("rst_grant_c0", {31'd0, o_DataGrant_C}, 32'd0);
    i_DataGrant_D = 1'b1;
    #1;
    chk("rst_grant_c1", {31'd0, o_DataGrant_C}, 32'd1);
    i_DataGrant_D = 1'b0;
    @(negedge CLK);

    // Buffer without grant: C words lost, then A/B alternate
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3*i, 1'b1, 3*i+1, 1'b1, 3*i+2, 1'b0);
      tick();
    end
    foreach (sb[i]) begin end
    for (int i = 0; i < 4; i++) begin
      sb.push_back(32'(3*i));
      sb.push_back(32'(3*i+1));
    end
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_valid", {31'd0, o_DataValid_D}, 32'd1);
    end
    tick();
    chk("t1_valid_end", {31'd0, o_DataValid_D}, 32'd0);
    chk("t1_sb_empty", sb.size(), 32'd0);

    // C priority with grant
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 12+3*i, 1'b1, 13+3*i, 1'b1, 14+3*i, 1'b1);
      sb.push_back(32'(14+3*i));
      tick();
      chk("t2_valid_c", {31'd0, o_DataValid_D}, 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      sb.push_back(32'(12+3*i));
      sb.push_back(32'(13+3*i));
    end
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_valid_ab", {31'd0, o_DataValid_D}, 32'd1);
    end
    tick();
    chk("t2_valid_end", {31'd0, o_DataValid_D}, 32'd0);
    chk("t2_sb_empty", sb.size(), 32'd0);

    // Overflow: pushes 9..12 dropped
    for (int i = 8; i < 20; i++) begin
      logic e;
      e = (i < 15);
      drive(1'b1, 3*i, 1'b1, 3*i+1, 1'b0, 0, 1'b0);
      tick();
      chk("t3_grant_a", {31'd0, o_DataGrant_A}, {31'd0, e});
      chk("t3_grant_b", {31'd0, o_DataGrant_B}, {31'd0, e});
    end
    for (int i = 8; i < 16; i++) begin
      sb.push_back(32'(3*i));
      sb.push_back(32'(3*i+1));
    end
    // Push while full on the same edge as the first pop must still be dropped
    drive(1'b1, 99, 1'b1, 98, 1'b0, 0, 1'b1);
    tick();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t3_valid", {31'd0, o_DataValid_D}, 32'd1);
    end
    tick();
    chk("t3_valid_end", {31'd0, o_DataValid_D}, 32'd0);
    chk("t3_grant_a_back", {31'd0, o_DataGrant_A}, 32'd1);
    chk("t3_grant_b_back", {31'd0, o_DataGrant_B}, 32'd1);
    chk("t3_sb_empty", sb.size(), 32'd0);

    // Single FIFO: each word appears two cycles after it is presented
    drive(1'b1, 5, 1'b0, 0, 1'b0, 0, 1'b1);
    sb.push_back(32'd5);
    tick();
    chk("t4_valid0", {31'd0, o_DataValid_D}, 32'd0);
    drive(1'b1, 6, 1'b0, 0, 1'b0, 0, 1'b1);
    sb.push_back(32'd6);
    tick();
    chk("t4_valid1", {31'd0, o_DataValid_D}, 32'd1);
    drive(1'b1, 7, 1'b0, 0, 1'b0, 0, 1'b1);
    sb.push_back(32'd7);
    tick();
    chk("t4_valid2", {31'd0, o_DataValid_D}, 32'd1);
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    tick();
    chk("t4_valid3", {31'd0, o_DataValid_D}, 32'd1);
    tick();
    chk("t4_valid4", {31'd0, o_DataValid_D}, 32'd0);
    chk("t4_sb_empty", sb.size(), 32'd0);

    // Reset mid-operation
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 80+i, 1'b0, 0, 1'b0, 0, 1'b0);
      tick();
    end
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    sb.push_back(32'd80);
    tick();
    sb.push_back(32'd81);
    tick();
    chk("t5_valid_pre", {31'd0, o_DataValid_D}, 32'd1);
    #2;
    ASynReset_N = 1'b0;
    #1;
    chk("t5_valid_rst", {31'd0, o_DataValid_D}, 32'd0);
    chk("t5_dout_rst", {24'd0, o_DataOut_D}, 32'd0);
    chk("t5_grant_a_rst", {31'd0, o_DataGrant_A}, 32'd1);
    last_word = '0;
    @(negedge CLK);
    ASynReset_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_output", {31'd0, o_DataValid_D}, 32'd0);
    end
    chk("t5_sb_empty", sb.size(), 32'd0);

    // Grant with gaps: idle output reads 0 or holds, depending on build
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 70+i, 1'b0, 0, 1'b0, 0, 1'b0);
      sb.push_back(32'(70+i));
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      logic g;
      g = ((i % 2) == 0);
      drive(1'b0, 0, 1'b0, 0, 1'b0, 0, g);
      tick();
      chk("t6_valid", {31'd0, o_DataValid_D}, {31'd0, g});
    end
    chk("t6_sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
